// File: rtl/tiny_soc_pkg.sv
// tiny_soc_pkg: shared region encoding, MMIO entry layout and default address map
package tiny_soc_pkg;
  typedef enum logic [1:0] {REGION_SRAM, REGION_MMIO, REGION_ILLEGAL} region_e;
  localparam int DefAddrWidth = 32;
  localparam int DefDataWidth = 64;
  localparam int DefMmioAddrWidth = 31;
  localparam logic [31:0] DefMemBase = 32'h8000_0000;
  localparam logic [31:0] DefMmioBase = 32'h0000_0000;
  localparam logic [31:0] DefMmioSize = 32'h1000_0000;
  typedef struct packed {
    logic [DefMmioAddrWidth-1:0] offset;
    logic [DefDataWidth-1:0] wdata;
    logic [DefDataWidth/8-1:0] strb;
  } mmio_entry_t;
endpackage

// File: rtl/tiny_soc_mem_ctrl_if.sv
// tiny_soc_mem_ctrl_if: core request/response port, MMIO drain port and error capture
interface tiny_soc_mem_ctrl_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int MMIOAddrWidth = 31
);
  logic req_i, gnt_o, we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [DataWidth-1:0] wdata_i;
  logic [DataWidth/8-1:0] strb_i;
  logic rvalid_o, err_o;
  logic [DataWidth-1:0] rdata_o;
  logic mmio_valid_o, mmio_ready_i;
  logic [MMIOAddrWidth-1:0] mmio_addr_o;
  logic [DataWidth-1:0] mmio_wdata_o;
  logic [DataWidth/8-1:0] mmio_strb_o;
  logic err_sticky_o;
  logic [AddrWidth-1:0] err_addr_o;
  modport slave (
    input req_i, we_i, addr_i, wdata_i, strb_i, mmio_ready_i,
    output gnt_o, rvalid_o, err_o, rdata_o, mmio_valid_o, mmio_addr_o, mmio_wdata_o, mmio_strb_o,
    err_sticky_o, err_addr_o
  );
  modport master (
    output req_i, we_i, addr_i, wdata_i, strb_i, mmio_ready_i,
    input gnt_o, rvalid_o, err_o, rdata_o, mmio_valid_o, mmio_addr_o, mmio_wdata_o, mmio_strb_o,
    err_sticky_o, err_addr_o
  );
endinterface

// File: rtl/tiny_soc_sram.sv
// tiny_soc_sram: single-port SRAM, byte-strobed write, registered 1-cycle read, array not reset
module tiny_soc_sram #(
  parameter int NumWords = 1024,
  parameter int DataWidth = 64,
  parameter int IdxW = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic [DataWidth-1:0]   rdata_o
);
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (strb_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (req_i && !we_i) rdata_q <= mem_q[idx_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/tiny_soc_mem_ctrl.sv
// tiny_soc_mem_ctrl: decodes core requests into SRAM, buffered MMIO writes or errors, fixed-latency in-order responses.
// Define TINY_SOC_ERR_STICKY_EN to capture the address of the first error after reset.
module tiny_soc_mem_ctrl
  import tiny_soc_pkg::*;
#(
  parameter int NumWords = 1 << 20,
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int MMIOAddrWidth = DefMmioAddrWidth,
  parameter logic [AddrWidth-1:0] MemBase = DefMemBase,
  parameter logic [AddrWidth-1:0] MmioBase = DefMmioBase,
  parameter logic [AddrWidth-1:0] MmioSize = DefMmioSize,
  parameter int ReadLatency = 1,
  parameter int MmioFifoDepth = 4
) (
  input logic clk_i,
  input logic rst_i,
  tiny_soc_mem_ctrl_if.slave bus
);
  localparam int StrbW = DataWidth / 8;
  localparam int IdxW = $clog2(NumWords);
  localparam int PtrW = $clog2(MmioFifoDepth);
  localparam int EntW = MMIOAddrWidth + DataWidth + StrbW;
  localparam int RespW = DataWidth + 2;
  localparam logic [AddrWidth:0] SramSize = (AddrWidth + 1)'(NumWords * StrbW);
  region_e region;
  logic [AddrWidth:0] sram_off, mmio_off;
  logic gnt, accept, mmio_wr, push, pop, full, fifo_vld, err_d, rd_d;
  logic vld_q, err_q, rd_q;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0] cnt_q;
  logic [EntW-1:0] fifo_q [MmioFifoDepth];
  logic [DataWidth-1:0] sram_rdata;
  logic [RespW-1:0] resp;
  // one extra bit makes addresses below a base wrap to a huge offset, failing the size check
  assign sram_off = {1'b0, bus.addr_i} - {1'b0, MemBase};
  assign mmio_off = {1'b0, bus.addr_i} - {1'b0, MmioBase};
  assign region = sram_off < SramSize ? REGION_SRAM :
                  mmio_off < {1'b0, MmioSize} ? REGION_MMIO : REGION_ILLEGAL;
  assign full = cnt_q == (PtrW + 1)'(MmioFifoDepth);
  assign mmio_wr = region == REGION_MMIO && bus.we_i;
  assign gnt = bus.req_i && !(mmio_wr && full);
  assign bus.gnt_o = gnt;
  assign accept = gnt && !rst_i;
  assign push = accept && mmio_wr;
  assign fifo_vld = cnt_q != '0;
  assign pop = fifo_vld && bus.mmio_ready_i;
  assign err_d = accept && (region == REGION_ILLEGAL || (region == REGION_MMIO && !bus.we_i));
  assign rd_d = accept && region == REGION_SRAM && !bus.we_i;
  tiny_soc_sram #(.NumWords(NumWords), .DataWidth(DataWidth)) u_sram (
    .clk_i,
    .req_i(accept && region == REGION_SRAM),
    .we_i(bus.we_i),
    .idx_i(IdxW'(sram_off >> $clog2(StrbW))),
    .wdata_i(bus.wdata_i),
    .strb_i(bus.strb_i),
    .rdata_o(sram_rdata)
  );
  always_ff @(posedge clk_i)
    {vld_q, err_q, rd_q} <= rst_i ? 3'b000 : {accept, err_d, rd_d};
  assign resp = {vld_q, err_q, rd_q ? sram_rdata : '0};
  if (ReadLatency > 1) begin : g_dly
    logic [ReadLatency-2:0][RespW-1:0] dly_q;
    always_ff @(posedge clk_i)
      dly_q <= rst_i ? '0 : ((ReadLatency - 1) * RespW)'({dly_q, resp});
    assign {bus.rvalid_o, bus.err_o, bus.rdata_o} = dly_q[ReadLatency-2];
  end else begin : g_nodly
    assign {bus.rvalid_o, bus.err_o, bus.rdata_o} = resp;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + PtrW'(push);
      rptr_q <= rptr_q + PtrW'(pop);
      cnt_q <= cnt_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) fifo_q[wptr_q] <= {MMIOAddrWidth'(mmio_off), bus.wdata_i, bus.strb_i};
  assign bus.mmio_valid_o = fifo_vld;
  assign {bus.mmio_addr_o, bus.mmio_wdata_o, bus.mmio_strb_o} = fifo_vld ? fifo_q[rptr_q] : '0;
`ifdef TINY_SOC_ERR_STICKY_EN
  logic sticky_q;
  logic [AddrWidth-1:0] eaddr_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sticky_q <= 1'b0;
      eaddr_q <= '0;
    end else if (err_d && !sticky_q) begin
      sticky_q <= 1'b1;
      eaddr_q <= bus.addr_i;
    end
  assign bus.err_sticky_o = sticky_q;
  assign bus.err_addr_o = eaddr_q;
`else
  assign bus.err_sticky_o = 1'b0;
  assign bus.err_addr_o = '0;
`endif
endmodule

// File: tb/tb_tiny_soc_mem_ctrl.sv
// tb_tiny_soc_mem_ctrl: directed and randomized checks of tiny_soc_mem_ctrl against a transaction-level model
module tb_tiny_soc_mem_ctrl;
  import tiny_soc_pkg::*;
  localparam int NW = 256;
  localparam int L = 2;
  localparam int FD = 4;
  localparam longint MEM_BASE = 64'h8000_0000;
  localparam longint MEM_END = MEM_BASE + NW * 8;
  localparam longint MMIO_BASE = 64'h0;
  localparam longint MMIO_END = 64'h1000_0000;
  typedef struct {
    int due;
    logic err;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] mem_m [NW];
  exp_t exp_q[$];
  mmio_entry_t mq[$];
  logic st_m = 1'b0;
  logic [31:0] sa_m = '0;
  tiny_soc_mem_ctrl_if #(.AddrWidth(32), .DataWidth(64), .MMIOAddrWidth(31)) bus ();
  tiny_soc_mem_ctrl #(.NumWords(NW), .ReadLatency(L), .MmioFifoDepth(FD)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic region_e region_of(input logic [31:0] a);
    longint x = {32'b0, a};
    if (x >= MEM_BASE && x < MEM_END) return REGION_SRAM;
    if (x >= MMIO_BASE && x < MMIO_END) return REGION_MMIO;
    return REGION_ILLEGAL;
  endfunction
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'(MEM_BASE) + 32'($urandom_range(0, NW * 8 - 1));
      4: return 32'(MEM_END) - 32'd8 + 32'($urandom_range(0, 15));
      5: return 32'(MEM_BASE) - 32'd8 + 32'($urandom_range(0, 15));
      6, 7: return 32'($urandom_range(0, 32'h0FFF_FFFF));
      8: return 32'(MMIO_END) - 32'd8 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction
  // one clock: apply inputs, check grant, advance the model, then check all outputs after the edge
  task automatic cycle(input logic rq, input logic wr, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic rdy, input logic rs);
    region_e rg;
    logic g, acc, e;
    int w;
    logic [63:0] rd;
    mmio_entry_t ent;
    exp_t x;
    bus.req_i = rq;
    bus.we_i = wr;
    bus.addr_i = a;
    bus.wdata_i = d;
    bus.strb_i = s;
    bus.mmio_ready_i = rdy;
    rst = rs;
    #2;
    rg = region_of(a);
    g = rq && !(rg == REGION_MMIO && wr && mq.size() == FD);
    check("gnt", bus.gnt_o, g);
    acc = g && !rs;
    e = rg == REGION_ILLEGAL || (rg == REGION_MMIO && !wr);
    rd = '0;
    if (acc && rg == REGION_SRAM) begin
      w = int'(({32'b0, a} - MEM_BASE) / 8);
      if (wr) begin
        for (int b = 0; b < 8; b++) if (s[b]) mem_m[w][b*8 +: 8] = d[b*8 +: 8];
      end else rd = mem_m[w];
    end
    if (acc) exp_q.push_back('{cyc + L, e, rd});
    if (rdy && mq.size() > 0) mq.delete(0);
    if (acc && rg == REGION_MMIO && wr) begin
      ent.offset = 31'({32'b0, a} - MMIO_BASE);
      ent.wdata = d;
      ent.strb = s;
      mq.push_back(ent);
    end
`ifdef TINY_SOC_ERR_STICKY_EN
    if (acc && e && !st_m) begin
      st_m = 1'b1;
      sa_m = a;
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      exp_q.delete();
      mq.delete();
      st_m = 1'b0;
      sa_m = '0;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      x = exp_q.pop_front();
      check("rvalid", bus.rvalid_o, 1'b1);
      check("err", bus.err_o, x.err);
      check("rdata", bus.rdata_o, x.data);
    end else begin
      check("rvalid", bus.rvalid_o, 1'b0);
      check("rdata_idle", bus.rdata_o, 64'h0);
    end
    check("mmio_valid", bus.mmio_valid_o, mq.size() > 0);
    check("mmio_addr", bus.mmio_addr_o, mq.size() > 0 ? 64'(mq[0].offset) : 64'h0);
    check("mmio_wdata", bus.mmio_wdata_o, mq.size() > 0 ? mq[0].wdata : 64'h0);
    check("mmio_strb", bus.mmio_strb_o, mq.size() > 0 ? 64'(mq[0].strb) : 64'h0);
    check("err_sticky", bus.err_sticky_o, st_m);
    check("err_addr", bus.err_addr_o, sa_m);
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, rdy, 1'b0);
  endtask
  initial begin
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("rst_err", bus.err_o, 1'b0);
    for (int i = 0; i < NW; i++)
      cycle(1'b1, 1'b1, 32'(MEM_BASE) + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0010, 64'h0, 8'h0F, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_0010, '0, '0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_0000, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_0008, '0, '0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 32'h100, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h100, 64'h5555_AAAA_0000_0005, 8'hFF, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h100, 64'h5555_AAAA_0000_0005, 8'hFF, 1'b0, 1'b0);
    idle(6, 1'b1);
    cycle(1'b1, 1'b0, 32'h200, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h7000_0000, '0, '0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    cycle(1'b1, 1'b1, 32'h300, 64'h1234, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_0010, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(L + 1, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_0010, '0, '0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rand_addr(), {$urandom, $urandom},
            8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    idle(L + 1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
